// File: rtl/cursor_pkg.sv
// Shared types and helpers for the pixel cursor controller.
package cursor_pkg;
  localparam int MATRIX_DIM = 8;

  typedef logic [2:0]        coord_t;
  typedef logic [23:0]       rgb_t;
  typedef logic signed [1:0] delta_t;

  typedef enum logic [1:0] {INIT, IDLE, ERASE, DRAW} cursor_state_t;

  // Opposite pulses on one axis cancel to zero.
  function automatic delta_t pulse_delta(input logic inc, input logic dec);
    if (inc && !dec) return 2'sd1;
    if (dec && !inc) return -2'sd1;
    return 2'sd0;
  endfunction

  // True when a non-zero step on one axis would be absorbed by a saturating edge.
  function automatic logic step_blocked(input coord_t p, input delta_t d, input logic wrap);
    return !wrap && (((d == 2'sd1) && (p == coord_t'(MATRIX_DIM - 1))) ||
                     ((d == -2'sd1) && (p == coord_t'(0))));
  endfunction
endpackage

// File: rtl/pixel_cursor_ctrl_if.sv
// Frame-buffer write port: valid/ready handshake with pixel address and RGB data.
interface pixel_cursor_ctrl_if;
  logic                wr_valid;
  logic                wr_ready;
  logic [5:0]          wr_addr;
  cursor_pkg::rgb_t    wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/axis_step.sv
// One-axis cursor step: wraps or saturates at the matrix edges.
module axis_step
  import cursor_pkg::*;
#(
  parameter bit WRAP = 1'b1
) (
  input  coord_t pos_i,
  input  delta_t delta_i,
  output coord_t pos_o
);
  localparam coord_t MAX_C = coord_t'(MATRIX_DIM - 1);

  always_comb begin
    pos_o = pos_i;
    if (delta_i == 2'sd1) begin
      if (pos_i == MAX_C) pos_o = WRAP ? coord_t'(0) : MAX_C;
      else                pos_o = pos_i + coord_t'(1);
    end else if (delta_i == -2'sd1) begin
      if (pos_i == coord_t'(0)) pos_o = WRAP ? MAX_C : coord_t'(0);
      else                      pos_o = pos_i - coord_t'(1);
    end
  end
endmodule

// File: rtl/pixel_cursor_ctrl.sv
// Cursor controller: turns direction pulses into erase/draw writes on the frame buffer.
module pixel_cursor_ctrl
  import cursor_pkg::*;
#(
  parameter coord_t X0         = 3'd0,
  parameter coord_t Y0         = 3'd0,
  parameter bit     WRAP       = 1'b1,
  parameter rgb_t   CURSOR_RGB = 24'hFF_FF_FF,
  parameter rgb_t   BG_RGB     = 24'h00_00_00
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       up,
  input  logic                       down,
  input  logic                       left,
  input  logic                       right,
  pixel_cursor_ctrl_if.master        wr,
  output coord_t                     cur_x,
  output coord_t                     cur_y,
  output logic                       busy
);
  cursor_state_t state_q, state_d;
  coord_t cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  coord_t old_x_q, old_x_d, old_y_q, old_y_d;
  logic   pend_vld_q, pend_vld_d;
  delta_t pend_dx_q, pend_dx_d, pend_dy_q, pend_dy_d;
  logic   wr_valid_q, wr_valid_d;
  logic [5:0] wr_addr_q, wr_addr_d;
  rgb_t   wr_data_q, wr_data_d;

  delta_t dx_live, dy_live, dx_sel, dy_sel;
  coord_t tgt_x, tgt_y;
  logic   live_nn, move_nn, hs, take;

  assign dx_live = pulse_delta(right, left);
  assign dy_live = pulse_delta(up, down);
  assign live_nn = ((dx_live != 2'sd0) && !step_blocked(cur_x_q, dx_live, WRAP)) ||
                   ((dy_live != 2'sd0) && !step_blocked(cur_y_q, dy_live, WRAP));

  // A fresh non-null pulse supersedes whatever is pending.
  assign dx_sel = live_nn ? dx_live : (pend_vld_q ? pend_dx_q : 2'sd0);
  assign dy_sel = live_nn ? dy_live : (pend_vld_q ? pend_dy_q : 2'sd0);

  axis_step #(.WRAP(WRAP)) u_step_x (.pos_i(cur_x_q), .delta_i(dx_sel), .pos_o(tgt_x));
  axis_step #(.WRAP(WRAP)) u_step_y (.pos_i(cur_y_q), .delta_i(dy_sel), .pos_o(tgt_y));

  assign move_nn = {tgt_y, tgt_x} != {cur_y_q, cur_x_q};
  assign hs      = wr_valid_q && wr.wr_ready;

  always_comb begin
    state_d    = state_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    old_x_d    = old_x_q;
    old_y_d    = old_y_q;
    pend_vld_d = pend_vld_q;
    pend_dx_d  = pend_dx_q;
    pend_dy_d  = pend_dy_q;
    take       = 1'b0;

    unique case (state_q)
      INIT:    if (hs) state_d = IDLE;
      IDLE:    take = 1'b1;
      ERASE:   if (hs) state_d = DRAW;
      DRAW:    if (hs) take = 1'b1;
      default: state_d = INIT;
    endcase

    if (take) begin
      pend_vld_d = 1'b0;
      if (move_nn) begin
        old_x_d = cur_x_q;
        old_y_d = cur_y_q;
        cur_x_d = tgt_x;
        cur_y_d = tgt_y;
        state_d = ERASE;
      end else begin
        state_d = IDLE;
      end
    end else if (live_nn) begin
      pend_vld_d = 1'b1;
      pend_dx_d  = dx_live;
      pend_dy_d  = dy_live;
    end

    // Request registers follow the next state so they are stable across stalls.
    wr_valid_d = state_d != IDLE;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    unique case (state_d)
      INIT:    begin wr_addr_d = {Y0, X0};           wr_data_d = CURSOR_RGB; end
      ERASE:   begin wr_addr_d = {old_y_d, old_x_d}; wr_data_d = BG_RGB;     end
      DRAW:    begin wr_addr_d = {cur_y_d, cur_x_d}; wr_data_d = CURSOR_RGB; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT;
      cur_x_q    <= X0;
      cur_y_q    <= Y0;
      old_x_q    <= X0;
      old_y_q    <= Y0;
      pend_vld_q <= 1'b0;
      pend_dx_q  <= 2'sd0;
      pend_dy_q  <= 2'sd0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 6'd0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      old_x_q    <= old_x_d;
      old_y_q    <= old_y_d;
      pend_vld_q <= pend_vld_d;
      pend_dx_q  <= pend_dx_d;
      pend_dy_q  <= pend_dy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign wr.wr_valid = wr_valid_q;
  assign wr.wr_addr  = wr_addr_q;
  assign wr.wr_data  = wr_data_q;
  assign cur_x       = cur_x_q;
  assign cur_y       = cur_y_q;
  assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_pixel_cursor_ctrl.sv
// Two controllers (wrapping and saturating) driven by shared random pulses,
// checked against a transaction-level cursor model and a write scoreboard.
module tb_pixel_cursor_ctrl;
  localparam logic [23:0] CUR1 = 24'h12_34_56;
  localparam logic [23:0] BG1  = 24'h0A_0B_0C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, rdy = 1'b1;
  logic [2:0] cx0, cy0, cx1, cy1;
  logic busy0, busy1;

  always #5 clk = ~clk;

  pixel_cursor_ctrl_if if0 ();
  pixel_cursor_ctrl_if if1 ();
  assign if0.wr_ready = rdy;
  assign if1.wr_ready = rdy;

  pixel_cursor_ctrl u0 (
    .clk(clk), .rst(rst), .up(up), .down(down), .left(left), .right(right),
    .wr(if0), .cur_x(cx0), .cur_y(cy0), .busy(busy0)
  );

  pixel_cursor_ctrl #(
    .X0(3'd3), .Y0(3'd5), .WRAP(1'b0), .CURSOR_RGB(CUR1), .BG_RGB(BG1)
  ) u1 (
    .clk(clk), .rst(rst), .up(up), .down(down), .left(left), .right(right),
    .wr(if1), .cur_x(cx1), .cur_y(cy1), .busy(busy1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 init write, 2 erase write, 3 draw write
  int          wrap [2] = '{1, 0};
  int          x0   [2] = '{0, 3};
  int          y0   [2] = '{0, 5};
  logic [23:0] fg   [2] = '{24'hFF_FF_FF, CUR1};
  logic [23:0] bg   [2] = '{24'h00_00_00, BG1};
  int mx [2], my [2], phase [2], pdx [2], pdy [2];
  bit pend [2], vfresh [2];
  logic [29:0] q0 [$];
  logic [29:0] q1 [$];

  function automatic int step_ax(input int i, input int p, input int d);
    int t;
    t = p + d;
    if (wrap[i] != 0) return (t + 8) % 8;
    return (t < 0) ? 0 : ((t > 7) ? 7 : t);
  endfunction

  task automatic push(input int i, input int x, input int y, input logic [23:0] c);
    logic [29:0] e;
    e = {y[2:0], x[2:0], c};
    if (i == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic mreset(input int i);
    mx[i] = x0[i]; my[i] = y0[i];
    phase[i] = 1; pend[i] = 1'b0; vfresh[i] = 1'b1;
    if (i == 0) q0.delete(); else q1.delete();
    push(i, x0[i], y0[i], fg[i]);
  endtask

  task automatic mmove(input int i, input int dx, input int dy);
    int tx, ty;
    tx = step_ax(i, mx[i], dx);
    ty = step_ax(i, my[i], dy);
    pend[i] = 1'b0;
    if (tx == mx[i] && ty == my[i]) phase[i] = 0;
    else begin
      push(i, mx[i], my[i], bg[i]);
      push(i, tx, ty, fg[i]);
      mx[i] = tx; my[i] = ty; phase[i] = 2;
    end
  endtask

  task automatic mstep(input int i, input int u, input int d, input int l, input int r, input int rd);
    bit hs, live;
    int dx, dy;
    hs = (phase[i] != 0) && !vfresh[i] && (rd != 0);
    vfresh[i] = 1'b0;
    dx = r - l;
    dy = u - d;
    live = (step_ax(i, mx[i], dx) != mx[i]) || (step_ax(i, my[i], dy) != my[i]);
    if (phase[i] == 0 || (phase[i] == 3 && hs)) begin
      if (live) mmove(i, dx, dy);
      else if (pend[i]) mmove(i, pdx[i], pdy[i]);
      else phase[i] = 0;
    end else begin
      if (live) begin pend[i] = 1'b1; pdx[i] = dx; pdy[i] = dy; end
      if (hs) phase[i] = (phase[i] == 1) ? 0 : 3;
    end
  endtask

  // ---------------- write monitor / scoreboard ----------------
  bit          pstall [2] = '{0, 0};
  logic [30:0] prev   [2];

  task automatic mon(input int i, input logic v, input logic [5:0] a, input logic [23:0] dt);
    logic [29:0] e;
    if (rst) begin pstall[i] = 1'b0; return; end
    if (pstall[i]) chk($sformatf("stall_hold%0d", i), {1'b0, v, a, dt}, {1'b0, prev[i]});
    if (v && rdy) begin
      if ((i == 0 ? q0.size() : q1.size()) == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write%0d: got %0h expected none", i, {a, dt});
      end else begin
        e = (i == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("write%0d", i), {2'b0, a, dt}, {2'b0, e});
      end
    end
    pstall[i] = v && !rdy;
    prev[i]   = {v, a, dt};
  endtask

  always @(negedge clk) begin
    mon(0, if0.wr_valid, if0.wr_addr, if0.wr_data);
    mon(1, if1.wr_valid, if1.wr_addr, if1.wr_data);
  end

  // ---------------- driver ----------------
  task automatic cyc(input int u, input int d, input int l, input int r, input int rd, input int rs);
    @(posedge clk);
    #1;
    chk("valid0", {31'b0, if0.wr_valid}, {31'b0, phase[0] != 0 && !vfresh[0]});
    chk("valid1", {31'b0, if1.wr_valid}, {31'b0, phase[1] != 0 && !vfresh[1]});
    chk("busy0",  {31'b0, busy0}, {31'b0, phase[0] != 0});
    chk("busy1",  {31'b0, busy1}, {31'b0, phase[1] != 0});
    chk("cur0",   {26'b0, cy0, cx0}, {26'b0, my[0][2:0], mx[0][2:0]});
    chk("cur1",   {26'b0, cy1, cx1}, {26'b0, my[1][2:0], mx[1][2:0]});
    if (rst) begin
      chk("rst_req0", {2'b0, if0.wr_addr, if0.wr_data}, 32'd0);
      chk("rst_req1", {2'b0, if1.wr_addr, if1.wr_data}, 32'd0);
    end
    rst = (rs != 0); up = (u != 0); down = (d != 0); left = (l != 0); right = (r != 0); rdy = (rd != 0);
    for (int i = 0; i < 2; i++) begin
      if (rs != 0) mreset(i);
      else mstep(i, u, d, l, r, rd);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    mreset(0);
    mreset(1);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 1);
    idle(4);                                   // INIT writes
    cyc(0, 0, 0, 1, 1, 0); idle(4);            // right
    repeat (5) begin cyc(0, 0, 1, 0, 1, 0); idle(4); end  // wrap / saturate left
    cyc(1, 1, 0, 0, 1, 0); idle(4);            // cancelled
    cyc(1, 0, 0, 1, 1, 0); idle(4);            // diagonal
    cyc(0, 0, 0, 1, 1, 0);                     // stall during ERASE with two pulses
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    idle(8);
    cyc(1, 0, 0, 0, 1, 0); idle(1);            // pulse on last DRAW handshake
    cyc(0, 0, 0, 1, 1, 0); idle(8);
    cyc(0, 0, 0, 1, 1, 0);                     // reset during DRAW stall
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 1);
    idle(6);
    for (int k = 0; k < 4000; k++) begin
      cyc(($urandom_range(0, 4) == 0) ? 1 : 0, ($urandom_range(0, 4) == 0) ? 1 : 0,
          ($urandom_range(0, 4) == 0) ? 1 : 0, ($urandom_range(0, 4) == 0) ? 1 : 0,
          ($urandom_range(0, 3) != 0) ? 1 : 0, ($urandom_range(0, 399) == 0) ? 1 : 0);
    end
    idle(12);
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pixel_cursor_ctrl.md
# pixel_cursor_ctrl

Cursor controller for the interactive-pixel design on the DM163 colour shield. It consumes the one-cycle direction pulses from the button front-end and keeps a cursor position on the 8x8 matrix. For every accepted move it runs an erase/draw write sequence into the frame buffer's single write port using a valid/ready handshake. It sits between the button block and the frame buffer that feeds the shield driver.

## Interface
- `X0`, default 0: cursor column after reset (0..7).
- `Y0`, default 0: cursor row after reset (0..7).
- `WRAP`, default 1: 1 = wrap at matrix edges; 0 = saturate.
- `CURSOR_RGB`, default 24'hFF_FF_FF: colour written at the new position.
- `BG_RGB`, default 24'h00_00_00: colour written at the vacated position.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `up`, `down`, `left`, `right`  in  1 each  one-cycle move pulses.
- `wr_valid`  out  1  write request to frame buffer.
- `wr_ready`  in  1  frame buffer accepts write when high together with `wr_valid`.
- `wr_addr`  out  6  pixel address {row[2:0], col[2:0]}.
- `wr_data`  out  24  RGB value {R,G,B}, 8 bits each.
- `cur_x`, `cur_y`  out  3 each  current cursor column/row.
- `busy`  out  1  high whenever state != IDLE.

## Operation
- States: INIT, IDLE, ERASE, DRAW.
- Reset: state=INIT, `cur_x`=X0, `cur_y`=Y0, pending cleared, `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `busy`=1.
- INIT: `wr_valid`=1, addr={Y0,X0}, data=CURSOR_RGB. On handshake, go to IDLE.
- Move decode (combinational, per cycle):
  - dy = up − down; dx = right − left.
  - Opposite pulses cancel. Orthogonal pulses give a diagonal move.
- Axis step:
  - WRAP=1: 7+1→0 and 0−1→7.
  - WRAP=0: result clamps at 0/7.
- A move is null if the target equals the current position (no pulses, cancelled pulses, or saturated at an edge). Null moves are discarded and produce no writes.
- IDLE, non-null move or pending move present:
  - Latch the old position.
  - Update `cur_x`/`cur_y` to the target.
  - Clear pending.
  - Go to ERASE.
- ERASE: `wr_valid`=1, addr=old position, data=BG_RGB. On handshake, go to DRAW.
- DRAW: `wr_valid`=1, addr=current position, data=CURSOR_RGB. On handshake:
  - If pending is valid, consume it (same actions as the IDLE move) and go to ERASE.
  - Otherwise go to IDLE.
- Pulses arriving while busy (INIT/ERASE/DRAW):
  - Non-null pulses go into a one-deep pending register storing the raw {dx,dy}. The last one wins.
  - Pending is evaluated against the cursor position at the time it is consumed. If that evaluation is null, discard it and go to IDLE.
- `wr_addr`/`wr_data` stay stable while `wr_valid`=1 and `wr_ready`=0. `wr_valid` never drops without a handshake.

## Timing
- Registered outputs. A pulse in IDLE at cycle n gives:
  - ERASE, new `cur_x`/`cur_y`, `wr_valid`=1 and `busy`=1 at n+1.
- With `wr_ready` held high:
  - erase write accepted at n+1;
  - draw write at n+2;
  - IDLE and `busy`=0 at n+3.
- One extra cycle per stalled `wr_ready` cycle.
- A pulse coinciding with the last DRAW handshake is taken as pending. ERASE follows with no IDLE gap.
- Reset asserted mid-sequence aborts immediately to the reset values. The partially written frame is not repaired.

## Structure
- Package `cursor_pkg`:
  - `coord_t` (3-bit);
  - `rgb_t` (24-bit);
  - `cursor_state_t` enum {INIT, IDLE, ERASE, DRAW};
  - `MATRIX_DIM`=8.
- Sub-module `axis_step`: coord_t in, signed 2-bit delta, WRAP parameter → coord_t out. Instantiated once per axis.

## Test plan
- Reset, `wr_ready`=1 → single write addr=0 (Y0=X0=0), data=FFFFFF. Then `busy`=0 and cur=(0,0).
- `right` pulse at (0,0) → writes (addr 0, 000000) then (addr 1, FFFFFF). cur_x=1 at n+1, `busy` low at n+3.
- WRAP=1, `left` at x=0 → cur_x=7, draw addr={y,7}. WRAP=0, same stimulus → no `wr_valid`, `busy` stays 0.
- `up`+`down` together → no writes. `up`+`right` at (2,2) → writes erase addr 18 and draw addr 27 (cur becomes (3,3)).
- `wr_ready` low 5 cycles during ERASE → `wr_valid`/addr/data held constant. Two pulses (`down`, then `right`) during the stall → only `right` executes afterwards.
- Assert `rst` during DRAW stall → next cycle `wr_valid`=0, state INIT, cur=(X0,Y0). INIT write follows after release.
